// File: rtl/park_token_if.sv
// Request/response bundle between the gate logic (master) and the parking token manager (slave).
interface park_token_if #(
  parameter int SPOT_W = 3,
  parameter int TOK_W  = 3
);
  logic [TOK_W-1:0]  pattern;
  logic              pattern_load;
  logic              entry_req;
  logic              exit_req;
  logic [SPOT_W-1:0] exit_spot;
  logic [TOK_W-1:0]  exit_token;
  logic              busy;
  logic              done;
  logic              grant;
  logic              deny;
  logic [SPOT_W-1:0] spot;
  logic [TOK_W-1:0]  token;
  logic [SPOT_W:0]   free_count;
  logic              full;

  modport master (
    output pattern, pattern_load, entry_req, exit_req, exit_spot, exit_token,
    input  busy, done, grant, deny, spot, token, free_count, full
  );

  modport slave (
    input  pattern, pattern_load, entry_req, exit_req, exit_spot, exit_token,
    output busy, done, grant, deny, spot, token, free_count, full
  );
endinterface

// File: rtl/park_token_manager.sv
// Parking spot allocator: issues a token per occupied spot on entry, verifies it on exit.
// state | meaning
// IDLE  | waiting; requests sampled here, exit wins over entry
// ALLOC | allocate lowest free spot and issue token, or refuse when full
// CHECK | compare presented token against stored one, free spot on match
// RESP  | done pulse with grant/deny
module park_token_manager #(
  parameter int SPOT_W    = 3,
  parameter int NUM_SPOTS = 8,
  parameter int TOK_W     = 3
) (
  input logic        clk,
  input logic        rst_n,
  park_token_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ALLOC, CHECK, RESP} state_t;

  localparam int              DEPTH    = 2 ** SPOT_W;
  localparam logic [SPOT_W:0] FREE_MAX = (SPOT_W + 1)'(NUM_SPOTS);

  state_t            state;
  logic [DEPTH-1:0]  occ;
  logic [TOK_W-1:0]  tok_tab [DEPTH];
  logic [TOK_W-1:0]  pattern_reg;
  logic [TOK_W-1:0]  seq;
  logic [SPOT_W:0]   free_cnt;
  logic [SPOT_W-1:0] ex_spot;
  logic [TOK_W-1:0]  ex_tok;
  logic              busy_r, done_r, grant_r, deny_r;
  logic [SPOT_W-1:0] spot_r;
  logic [TOK_W-1:0]  token_r;

  logic [SPOT_W-1:0] free_idx;
  logic [TOK_W-1:0]  alloc_tok;
  logic              exit_ok;

  // Scan downwards so the last hit is the lowest free index.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) free_idx = SPOT_W'(i);
    end
  end

  assign alloc_tok = (TOK_W'(free_idx) ^ pattern_reg) + seq;
  assign exit_ok   = (int'(ex_spot) < NUM_SPOTS) && occ[ex_spot] && (tok_tab[ex_spot] == ex_tok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      occ         <= '0;
      for (int i = 0; i < DEPTH; i++) tok_tab[i] <= '0;
      pattern_reg <= '0;
      seq         <= '0;
      free_cnt    <= FREE_MAX;
      ex_spot     <= '0;
      ex_tok      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      grant_r     <= 1'b0;
      deny_r      <= 1'b0;
      spot_r      <= '0;
      token_r     <= '0;
    end else begin
      if (bus.pattern_load) pattern_reg <= bus.pattern;
      case (state)
        IDLE: begin
          if (bus.exit_req) begin
            state   <= CHECK;
            busy_r  <= 1'b1;
            ex_spot <= bus.exit_spot;
            ex_tok  <= bus.exit_token;
          end else if (bus.entry_req) begin
            state  <= ALLOC;
            busy_r <= 1'b1;
          end
        end
        ALLOC: begin
          state  <= RESP;
          done_r <= 1'b1;
          if (free_cnt != '0) begin
            occ[free_idx]     <= 1'b1;
            tok_tab[free_idx] <= alloc_tok;
            free_cnt          <= free_cnt - 1'b1;
            seq               <= seq + 1'b1;
            grant_r           <= 1'b1;
            spot_r            <= free_idx;
            token_r           <= alloc_tok;
          end else begin
            deny_r <= 1'b1;
          end
        end
        CHECK: begin
          state  <= RESP;
          done_r <= 1'b1;
          if (exit_ok && (free_cnt < FREE_MAX)) begin
            occ[ex_spot] <= 1'b0;
            free_cnt     <= free_cnt + 1'b1;
            grant_r      <= 1'b1;
            spot_r       <= ex_spot;
          end else begin
            deny_r <= 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          grant_r <= 1'b0;
          deny_r  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.grant      = grant_r;
  assign bus.deny       = deny_r;
  assign bus.spot       = spot_r;
  assign bus.token      = token_r;
  assign bus.free_count = free_cnt;
  assign bus.full       = (free_cnt == '0);
endmodule

// File: tb/tb_park_token_manager.sv
// Directed bench for park_token_manager: expected responses are queued at request time and popped on done.
module tb_park_token_manager;
  localparam int SPOT_W    = 3;
  localparam int NUM_SPOTS = 8;
  localparam int TOK_W     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  park_token_if #(.SPOT_W(SPOT_W), .TOK_W(TOK_W)) bus ();

  park_token_manager #(.SPOT_W(SPOT_W), .NUM_SPOTS(NUM_SPOTS), .TOK_W(TOK_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic              grant;
    logic              deny;
    logic [SPOT_W-1:0] spot;
    logic [TOK_W-1:0]  token;
    logic [SPOT_W:0]   free_count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic              m_occ [NUM_SPOTS];
  logic [TOK_W-1:0]  m_tab [NUM_SPOTS];
  logic [TOK_W-1:0]  m_seq, m_pat, m_token;
  logic [SPOT_W-1:0] m_spot;
  int                m_free;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SPOTS; i++) begin
      m_occ[i] = 1'b0;
      m_tab[i] = '0;
    end
    m_seq = '0; m_pat = '0; m_token = '0; m_spot = '0;
    m_free = NUM_SPOTS;
  endtask

  task automatic push_exp(input logic g);
    exp_t e;
    e.grant = g;
    e.deny = !g;
    e.spot = m_spot;
    e.token = m_token;
    e.free_count = (SPOT_W + 1)'(m_free);
    exp_q.push_back(e);
  endtask

  task automatic expect_entry();
    int s;
    logic [TOK_W-1:0] sv;
    s = -1;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) if (!m_occ[i]) s = i;
    if (s >= 0) begin
      sv = s[TOK_W-1:0];
      m_token = (sv ^ m_pat) + m_seq;
      m_spot = s[SPOT_W-1:0];
      m_occ[s] = 1'b1;
      m_tab[s] = m_token;
      m_seq = m_seq + 1'b1;
      m_free--;
      push_exp(1'b1);
    end else begin
      push_exp(1'b0);
    end
  endtask

  task automatic expect_exit(input int s, input logic [TOK_W-1:0] t);
    if (s < NUM_SPOTS && m_occ[s] && m_tab[s] == t) begin
      m_occ[s] = 1'b0;
      m_free++;
      m_spot = s[SPOT_W-1:0];
      push_exp(1'b1);
    end else begin
      push_exp(1'b0);
    end
  endtask

  // Called at the negedge where the request was driven; waits for done (bounded).
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 10);
    check({tag, " latency"}, n, exp_lat);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " grant"}, bus.grant, e.grant);
      check({tag, " deny"}, bus.deny, e.deny);
      check({tag, " spot"}, bus.spot, e.spot);
      check({tag, " token"}, bus.token, e.token);
      check({tag, " free_count"}, bus.free_count, e.free_count);
      check({tag, " full"}, bus.full, (e.free_count == 0));
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, " done_clr"}, bus.done, 1'b0);
    check({tag, " busy_clr"}, bus.busy, 1'b0);
  endtask

  task automatic entry_txn(input string tag);
    bus.entry_req = 1'b1;
    expect_entry();
    wait_done(tag, 2);
    bus.entry_req = 1'b0;
    after_done(tag);
  endtask

  task automatic exit_txn(input string tag, input int s, input logic [TOK_W-1:0] t);
    bus.exit_spot = s[SPOT_W-1:0];
    bus.exit_token = t;
    bus.exit_req = 1'b1;
    expect_exit(s, t);
    wait_done(tag, 2);
    bus.exit_req = 1'b0;
    after_done(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, bus.busy, 1'b0);
    check({tag, " done"}, bus.done, 1'b0);
    check({tag, " grant"}, bus.grant, 1'b0);
    check({tag, " deny"}, bus.deny, 1'b0);
    check({tag, " spot"}, bus.spot, 0);
    check({tag, " token"}, bus.token, 0);
    check({tag, " full"}, bus.full, 1'b0);
    check({tag, " free_count"}, bus.free_count, NUM_SPOTS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pattern = '0; bus.pattern_load = 1'b0;
    bus.entry_req = 1'b0; bus.exit_req = 1'b0;
    bus.exit_spot = '0; bus.exit_token = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: load pattern 101, first entry
    bus.pattern = 3'b101; bus.pattern_load = 1'b1;
    @(negedge clk);
    bus.pattern_load = 1'b0; m_pat = 3'b101;
    entry_txn("entry1");
    check("entry1 spot const", bus.spot, 0);
    check("entry1 token const", bus.token, 3'b101);
    check("entry1 free const", bus.free_count, 7);

    // Test 2: second entry, exit, repeated exit
    entry_txn("entry2");
    check("entry2 spot const", bus.spot, 1);
    check("entry2 token const", bus.token, 3'b101);
    check("entry2 free const", bus.free_count, 6);
    exit_txn("exit1", 1, 3'b101);
    check("exit1 free const", bus.free_count, 7);
    exit_txn("exit1_again", 1, 3'b101);
    check("exit1_again deny hold", bus.free_count, 7);

    // Test 3: wrong token on occupied spot
    exit_txn("bad_token", 0, 3'b000);

    // Test 4: fill everything, then one more entry
    for (int i = 0; i < 7; i++) entry_txn("fill");
    check("filled full", bus.full, 1'b1);
    check("filled free", bus.free_count, 0);
    entry_txn("entry_when_full");

    // Test 5: simultaneous exit and entry while full
    bus.exit_spot = 3'd3; bus.exit_token = m_tab[3];
    bus.exit_req = 1'b1; bus.entry_req = 1'b1;
    expect_exit(3, m_tab[3]);
    expect_entry();
    wait_done("conc_exit", 2);
    check("conc_exit free const", bus.free_count, 1);
    bus.exit_req = 1'b0;
    after_done("conc_exit");
    wait_done("conc_entry", 2);
    bus.entry_req = 1'b0;
    after_done("conc_entry");
    check("conc_entry spot const", bus.spot, 3);
    check("conc_entry full", bus.full, 1'b1);

    // Pattern loaded at the allocation edge must not affect that token
    exit_txn("exit5", 5, m_tab[5]);
    bus.entry_req = 1'b1;
    expect_entry();
    @(negedge clk);
    bus.pattern = 3'b010; bus.pattern_load = 1'b1;
    m_pat = 3'b010;
    wait_done("load_in_alloc", 1);
    bus.pattern_load = 1'b0;
    bus.entry_req = 1'b0;
    after_done("load_in_alloc");

    // Test 6: reset during ALLOC
    exit_txn("exit2", 2, m_tab[2]);
    bus.entry_req = 1'b1;
    @(negedge clk);
    check("alloc busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    bus.entry_req = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_reset no_done", bus.done, 1'b0);
    end
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    entry_txn("post_reset");
    check("post_reset spot const", bus.spot, 0);
    check("post_reset token const", bus.token, 0);
    check("post_reset free const", bus.free_count, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
